// File: rtl/wb_cmd_master.sv
// -----------------------------------------------------------------------------
// wb_cmd_master
//
// Wishbone classic single-transfer initiator. Write/read commands are queued
// in a small FIFO and issued strictly in order, one outstanding transfer at a
// time. Each command produces exactly one response (read data or zero, plus a
// timeout error flag). A transfer whose strobe is held TIMEOUT_CYCLES cycles
// without an acknowledge is aborted and reported as an error.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready command handshake (ready = FIFO not full)
//   i_cmd_we/adr/data       command payload (data ignored for reads)
//   o_rsp_valid/i_rsp_ready response handshake
//   o_rsp_data, o_rsp_err   read data (0 for writes/errors), timeout flag
//   o_fifo_level            number of queued commands
//   o_busy                  FSM active or commands queued
//   o_err_count             saturating timeout counter
//   o_wb_*, i_wb_*          Wishbone classic initiator port
// -----------------------------------------------------------------------------
module wb_cmd_master #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int ADR_W          = 16,
   parameter int DAT_W          = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_cmd_valid,
   output logic                          o_cmd_ready,
   input  logic                          i_cmd_we,
   input  logic [ADR_W-1:0]              i_cmd_adr,
   input  logic [DAT_W-1:0]              i_cmd_data,
   output logic                          o_rsp_valid,
   input  logic                          i_rsp_ready,
   output logic [DAT_W-1:0]              o_rsp_data,
   output logic                          o_rsp_err,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
   output logic                          o_busy,
   output logic [7:0]                    o_err_count,
   output logic                          o_wb_cyc,
   output logic                          o_wb_stb,
   output logic                          o_wb_we,
   output logic [ADR_W-1:0]              o_wb_adr,
   output logic [DAT_W-1:0]              o_wb_data,
   input  logic                          i_wb_ack,
   input  logic [DAT_W-1:0]              i_wb_data
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CMD_W = 1 + ADR_W + DAT_W;
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // ---------------------------------------------------------------------
   // Command FIFO
   // ---------------------------------------------------------------------
   logic [CMD_W-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q,  level_d;
   logic [CMD_W-1:0] head;
   logic             push;
   logic             pop;

   // ---------------------------------------------------------------------
   // Bus / response state
   // ---------------------------------------------------------------------
   logic [1:0]       state_q, state_d;
   logic             wb_cyc_q, wb_cyc_d;
   logic             wb_we_q, wb_we_d;
   logic [ADR_W-1:0] wb_adr_q, wb_adr_d;
   logic [DAT_W-1:0] wb_data_q, wb_data_d;
   logic [TMO_W-1:0] tmo_q, tmo_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [DAT_W-1:0] rsp_data_q, rsp_data_d;
   logic             rsp_err_q, rsp_err_d;
   logic [7:0]       err_count_q, err_count_d;

   // Ready is forced low while reset is held so nothing can be queued into
   // a FIFO that is being cleared.
   assign o_cmd_ready = i_rst_n && (level_q != LVL_FULL);
   assign push        = i_cmd_valid && o_cmd_ready;
   assign pop         = (state_q == ST_IDLE) && (level_q != '0);
   assign head        = fifo_mem[rd_ptr_q];

   // Storage carries no reset: stale entries are unreachable once the
   // pointers and level are cleared.
   always_ff @(posedge i_clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {i_cmd_we, i_cmd_adr, i_cmd_data};
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // ---------------------------------------------------------------------
   // Transfer FSM
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      wb_cyc_d    = wb_cyc_q;
      wb_we_d     = wb_we_q;
      wb_adr_d    = wb_adr_q;
      wb_data_d   = wb_data_q;
      tmo_d       = tmo_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      err_count_d = err_count_q;

      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               wb_cyc_d                       = 1'b1;
               {wb_we_d, wb_adr_d, wb_data_d} = head;
               tmo_d                          = '0;
               state_d                        = ST_BUS;
            end
         end

         ST_BUS: begin
            // Ack is checked first so an ack in the last allowed cycle
            // still completes the transfer normally.
            if (i_wb_ack) begin
               wb_cyc_d    = 1'b0;
               wb_we_d     = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_data_d  = wb_we_q ? '0 : i_wb_data;
               state_d     = ST_RESP;
            end else if (tmo_q == TMO_LAST) begin
               wb_cyc_d    = 1'b0;
               wb_we_d     = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_data_d  = '0;
               if (err_count_q != 8'hFF) begin
                  err_count_d = err_count_q + 8'd1;
               end
               state_d     = ST_RESP;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         // Always at least one cycle here, which keeps cyc low long enough
         // for a registered slave ack to clear before the next transfer.
         ST_RESP: begin
            if (i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            state_d  = ST_IDLE;
            wb_cyc_d = 1'b0;
            wb_we_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         state_q     <= ST_IDLE;
         wb_cyc_q    <= 1'b0;
         wb_we_q     <= 1'b0;
         wb_adr_q    <= '0;
         wb_data_q   <= '0;
         tmo_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         err_count_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         state_q     <= state_d;
         wb_cyc_q    <= wb_cyc_d;
         wb_we_q     <= wb_we_d;
         wb_adr_q    <= wb_adr_d;
         wb_data_q   <= wb_data_d;
         tmo_q       <= tmo_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         err_count_q <= err_count_d;
      end
   end

   assign o_wb_cyc     = wb_cyc_q;
   assign o_wb_stb     = wb_cyc_q;
   assign o_wb_we      = wb_we_q;
   assign o_wb_adr     = wb_adr_q;
   assign o_wb_data    = wb_data_q;
   assign o_rsp_valid  = rsp_valid_q;
   assign o_rsp_data   = rsp_data_q;
   assign o_rsp_err    = rsp_err_q;
   assign o_err_count  = err_count_q;
   assign o_fifo_level = level_q;
   assign o_busy       = (state_q != ST_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_wb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_wb_cmd_master
//
// Scoreboard bench for wb_cmd_master. Each accepted command is run through a
// behavioural model (a 16-word memory standing in for the peripheral plus a
// saturating error tally) to produce the expected response and the expected
// Wishbone cycle; monitors pop and compare as the DUT presents them. A slave
// model answers each cycle after a per-command ack delay (0 = never acks) and
// holds its ack one extra cycle like a registered slave.
// -----------------------------------------------------------------------------
module tb_wb_cmd_master;

   localparam int FIFO_DEPTH     = 4;
   localparam int TIMEOUT_CYCLES = 16;
   localparam int ADR_W          = 16;
   localparam int DAT_W          = 16;

   logic              clk = 1'b0;
   logic              i_rst_n;
   logic              i_cmd_valid;
   logic              o_cmd_ready;
   logic              i_cmd_we;
   logic [ADR_W-1:0]  i_cmd_adr;
   logic [DAT_W-1:0]  i_cmd_data;
   logic              o_rsp_valid;
   logic              i_rsp_ready;
   logic [DAT_W-1:0]  o_rsp_data;
   logic              o_rsp_err;
   logic [2:0]        o_fifo_level;
   logic              o_busy;
   logic [7:0]        o_err_count;
   logic              o_wb_cyc;
   logic              o_wb_stb;
   logic              o_wb_we;
   logic [ADR_W-1:0]  o_wb_adr;
   logic [DAT_W-1:0]  o_wb_data;
   logic              i_wb_ack;
   logic [DAT_W-1:0]  i_wb_data;

   always #5 clk = ~clk;

   wb_cmd_master #(
      .FIFO_DEPTH    (FIFO_DEPTH),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .ADR_W         (ADR_W),
      .DAT_W         (DAT_W)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (i_rst_n),
      .i_cmd_valid (i_cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd_we    (i_cmd_we),
      .i_cmd_adr   (i_cmd_adr),
      .i_cmd_data  (i_cmd_data),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_data  (o_rsp_data),
      .o_rsp_err   (o_rsp_err),
      .o_fifo_level(o_fifo_level),
      .o_busy      (o_busy),
      .o_err_count (o_err_count),
      .o_wb_cyc    (o_wb_cyc),
      .o_wb_stb    (o_wb_stb),
      .o_wb_we     (o_wb_we),
      .o_wb_adr    (o_wb_adr),
      .o_wb_data   (o_wb_data),
      .i_wb_ack    (i_wb_ack),
      .i_wb_data   (i_wb_data)
   );

   typedef struct {
      logic [15:0] data;
      logic        err;
      logic [7:0]  errcnt;
   } rsp_t;

   typedef struct {
      logic        we;
      logic [15:0] adr;
      logic [15:0] data;
      int          len;
   } wb_t;

   rsp_t        exp_q[$];
   wb_t         wb_q[$];
   int          dly_q[$];
   logic [15:0] ref_mem [16];
   logic [15:0] slv_mem [16];
   int          model_err = 0;
   int          n_pass    = 0;
   int          n_total   = 0;
   int          rsp_n     = 0;
   logic        rand_ready  = 1'b0;
   logic        fixed_ready = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   // Expected outcome of one command, in issue order.
   function automatic void record(input logic we, input logic [15:0] adr,
                                  input logic [15:0] data, input int d);
      rsp_t r;
      wb_t  w;
      if (d == 0) begin
         model_err = (model_err < 255) ? model_err + 1 : 255;
         r.data = 16'h0;
         r.err  = 1'b1;
      end else begin
         r.err = 1'b0;
         if (we) begin
            ref_mem[adr[3:0]] = data;
            r.data = 16'h0;
         end else begin
            r.data = ref_mem[adr[3:0]];
         end
      end
      r.errcnt = 8'(model_err);
      exp_q.push_back(r);
      w.we   = we;
      w.adr  = adr;
      w.data = data;
      w.len  = (d == 0) ? TIMEOUT_CYCLES : d;
      wb_q.push_back(w);
      dly_q.push_back(d);
   endfunction

   task automatic push(input logic we, input logic [15:0] adr, input logic [15:0] data, input int d);
      int waited = 0;
      @(negedge clk);
      while (!o_cmd_ready && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      if (!o_cmd_ready) begin
         n_total++;
         $display("FAIL push_wait: o_cmd_ready=0 after %0d cycles, required 1", waited);
      end else begin
         i_cmd_we    = we;
         i_cmd_adr   = adr;
         i_cmd_data  = data;
         i_cmd_valid = 1'b1;
         record(we, adr, data, d);
         @(posedge clk);
         #1 i_cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_idle(input int budget, input string name);
      int c = 0;
      while ((o_busy || o_rsp_valid || exp_q.size() != 0) && c < budget) begin
         @(negedge clk);
         c++;
      end
      n_total++;
      if (c < budget) n_pass++;
      else $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
   endtask

   // Response ready driver (single writer of i_rsp_ready).
   initial begin
      i_rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1 i_rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
      end
   end

   // Slave model: ack in stb cycle d, held one further cycle.
   initial begin
      int          j;
      int          cur_d;
      logic        nack;
      logic [15:0] ndata;
      j = 0;
      cur_d = 0;
      i_wb_ack  = 1'b0;
      i_wb_data = 16'h0;
      forever begin
         @(negedge clk);
         nack  = 1'b0;
         ndata = 16'($urandom);
         if (!i_rst_n || !(o_wb_cyc && o_wb_stb)) begin
            j = 0;
         end else begin
            j++;
            if (j == 1) cur_d = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
            nack = (cur_d != 0) && (j == cur_d - 1 || j == cur_d);
            if (cur_d != 0 && j == cur_d - 1) begin
               if (o_wb_we) slv_mem[o_wb_adr[3:0]] = o_wb_data;
               else         ndata = slv_mem[o_wb_adr[3:0]];
            end
         end
         @(posedge clk);
         #1;
         i_wb_ack  = nack;
         i_wb_data = ndata;
      end
   end

   // Response monitor.
   initial begin
      rsp_t r;
      forever begin
         @(negedge clk);
         if (i_rst_n && o_rsp_valid && i_rsp_ready) begin
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL rsp_unexpected: got data=0x%0h err=%0b, required no response", o_rsp_data, o_rsp_err);
            end else begin
               r = exp_q.pop_front();
               check("rsp_data", 32'(o_rsp_data), 32'(r.data));
               check("rsp_err", 32'(o_rsp_err), 32'(r.err));
               check("err_count", 32'(o_err_count), 32'(r.errcnt));
               $display("rsp %0d: data=0x%04h err=%0b err_count=%0d", rsp_n, o_rsp_data, o_rsp_err, o_err_count);
               rsp_n++;
            end
         end
      end
   end

   // Wishbone monitor: command order, hold stability, strobe length, idle we.
   initial begin
      int   len;
      logic active;
      wb_t  cur;
      len = 0;
      active = 1'b0;
      forever begin
         @(negedge clk);
         if (!i_rst_n) begin
            len = 0;
            active = 1'b0;
         end else if (o_wb_cyc) begin
            if (len == 0) begin
               if (wb_q.size() == 0) begin
                  n_total++;
                  active = 1'b0;
                  $display("FAIL wb_unexpected: cycle adr=0x%0h, required no cycle", o_wb_adr);
               end else begin
                  cur = wb_q.pop_front();
                  active = 1'b1;
               end
            end
            len++;
            check("wb_stb_high", 32'(o_wb_stb), 32'd1);
            if (active) begin
               check("wb_we", 32'(o_wb_we), 32'(cur.we));
               check("wb_adr", 32'(o_wb_adr), 32'(cur.adr));
               if (cur.we) check("wb_data", 32'(o_wb_data), 32'(cur.data));
            end
         end else begin
            check("wb_stb_low", 32'(o_wb_stb), 32'd0);
            check("wb_we_idle", 32'(o_wb_we), 32'd0);
            if (len > 0) begin
               if (active) begin
                  check("stb_len", 32'(len), 32'(cur.len));
                  $display("wb %s adr=0x%04h stb_cycles=%0d", cur.we ? "wr" : "rd", cur.adr, len);
               end
               len = 0;
               active = 1'b0;
            end
         end
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic any_cyc;
      for (int i = 0; i < 16; i++) begin
         ref_mem[i] = 16'h0;
         slv_mem[i] = 16'h0;
      end
      i_rst_n     = 1'b0;
      i_cmd_valid = 1'b0;
      i_cmd_we    = 1'b0;
      i_cmd_adr   = '0;
      i_cmd_data  = '0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
      check("rst_cyc", 32'(o_wb_cyc), 32'd0);
      check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("rst_level", 32'(o_fifo_level), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_err_count", 32'(o_err_count), 32'd0);
      i_rst_n = 1'b1;
      #1 check("ready_after_rst", 32'(o_cmd_ready), 32'd1);
      repeat (2) @(negedge clk);

      // Write then read with registered-ack slave, latency checked per edge
      @(negedge clk);
      i_cmd_we = 1'b1; i_cmd_adr = 16'h0002; i_cmd_data = 16'h0064; i_cmd_valid = 1'b1;
      record(1'b1, 16'h0002, 16'h0064, 2);
      @(negedge clk);
      check("lat_cyc_k", 32'(o_wb_cyc), 32'd0);
      check("lat_level_k", 32'(o_fifo_level), 32'd1);
      i_cmd_we = 1'b0; i_cmd_adr = 16'h0002; i_cmd_data = 16'hFFFF;
      record(1'b0, 16'h0002, 16'hFFFF, 2);
      @(negedge clk);
      i_cmd_valid = 1'b0;
      check("lat_cyc_k1", 32'(o_wb_cyc), 32'd1);
      check("lat_level_k1", 32'(o_fifo_level), 32'd1);
      @(negedge clk);
      check("lat_rsp_k2", 32'(o_rsp_valid), 32'd0);
      @(negedge clk);
      check("lat_rsp_k3", 32'(o_rsp_valid), 32'd1);
      check("lat_cyc_k3", 32'(o_wb_cyc), 32'd0);
      @(negedge clk);
      check("lat_cyc_k4", 32'(o_wb_cyc), 32'd0);
      @(negedge clk);
      check("lat_cyc_k5", 32'(o_wb_cyc), 32'd1);
      wait_idle(100, "idle_wr_rd");

      // Timeout, then a normal transfer; the failed write must not land
      push(1'b1, 16'h0005, 16'hBEEF, 0);
      push(1'b0, 16'h0005, 16'h0000, 2);
      wait_idle(200, "idle_timeout");
      check("err_count_timeout", 32'(o_err_count), 32'd1);

      // Ack in the final allowed strobe cycle
      push(1'b1, 16'h0006, 16'h1234, 2);
      push(1'b0, 16'h0006, 16'h0000, TIMEOUT_CYCLES);
      wait_idle(200, "idle_last_ack");
      check("err_count_last_ack", 32'(o_err_count), 32'd1);

      // Back-pressure: fill the FIFO behind a stalled response
      fixed_ready = 1'b0;
      @(posedge clk);
      for (int i = 0; i < 5; i++) push(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom), 2);
      repeat (4) @(negedge clk);
      check("bp_level", 32'(o_fifo_level), 32'd4);
      check("bp_cmd_ready", 32'(o_cmd_ready), 32'd0);
      check("bp_busy", 32'(o_busy), 32'd1);
      check("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
      i_cmd_we = 1'b1; i_cmd_adr = 16'h0009; i_cmd_data = 16'hDEAD; i_cmd_valid = 1'b1;
      @(posedge clk);
      #1 i_cmd_valid = 1'b0;
      check("bp_level_after_6th", 32'(o_fifo_level), 32'd4);
      fixed_ready = 1'b1;
      wait_idle(300, "idle_backpressure");
      check("bp_level_drained", 32'(o_fifo_level), 32'd0);
      check("bp_busy_drained", 32'(o_busy), 32'd0);

      // Randomized traffic with random response back-pressure
      rand_ready = 1'b1;
      for (int i = 0; i < 120; i++) begin
         int d;
         d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, TIMEOUT_CYCLES));
         repeat ($urandom_range(0, 2)) @(negedge clk);
         push(1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom), d);
      end
      @(negedge clk);
      rand_ready = 1'b0;
      wait_idle(4000, "idle_random");

      // Asynchronous reset in the middle of a bus cycle with 2 queued
      push(1'b0, 16'h0003, 16'h0000, 0);
      push(1'b0, 16'h0004, 16'h0000, 0);
      push(1'b0, 16'h0005, 16'h0000, 0);
      @(posedge clk);
      #3 i_rst_n = 1'b0;
      #1;
      check("arst_cyc", 32'(o_wb_cyc), 32'd0);
      check("arst_stb", 32'(o_wb_stb), 32'd0);
      @(negedge clk);
      check("arst_level", 32'(o_fifo_level), 32'd0);
      check("arst_rsp_valid", 32'(o_rsp_valid), 32'd0);
      check("arst_err_count", 32'(o_err_count), 32'd0);
      check("arst_busy", 32'(o_busy), 32'd0);
      exp_q.delete();
      wb_q.delete();
      dly_q.delete();
      model_err = 0;
      @(negedge clk);
      i_rst_n = 1'b1;
      any_cyc = 1'b0;
      repeat (20) begin
         @(negedge clk);
         any_cyc = any_cyc | o_wb_cyc;
      end
      check("no_cycle_after_reset", 32'(any_cyc), 32'd0);

      // Saturating error counter
      for (int i = 0; i < 260; i++) push(1'b0, 16'($urandom_range(0, 15)), 16'h0000, 0);
      wait_idle(8000, "idle_saturation");
      check("err_count_saturated", 32'(o_err_count), 32'd255);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone single-transfer initiator that programs and polls the team's Wishbone-slave peripherals (pwm_timer channel registers).
- Firmware or test logic pushes write/read commands into a command FIFO; the block issues them in order as classic single Wishbone cycles.
- Returns one response per command: read data or zero, plus a timeout error flag.
- Sits on the i_clk domain in front of the peripheral's i_wb_* port.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, >=2
TIMEOUT_CYCLES, 16, max cycles stb held without ack before abort; >=2
ADR_W, 16, address width
DAT_W, 16, data width

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_cmd_valid  in  1  command offered
o_cmd_ready  out  1  FIFO not full
i_cmd_we  in  1  1=write, 0=read
i_cmd_adr  in  ADR_W  target address
i_cmd_data  in  DAT_W  write data; ignored for reads
o_rsp_valid  out  1  response available
i_rsp_ready  in  1  response consumed
o_rsp_data  out  DAT_W  read data; 0 for writes and errors
o_rsp_err  out  1  transfer timed out
o_fifo_level  out  $clog2(FIFO_DEPTH)+1  commands queued
o_busy  out  1  FSM not IDLE or FIFO non-empty
o_err_count  out  8  timeout count, saturates at 255
o_wb_cyc  out  1  Wishbone cycle
o_wb_stb  out  1  Wishbone strobe
o_wb_we  out  1  Wishbone write enable
o_wb_adr  out  ADR_W  Wishbone address
o_wb_data  out  DAT_W  Wishbone write data
i_wb_ack  in  1  Wishbone acknowledge
i_wb_data  in  DAT_W  Wishbone read data

Behaviour:
- Reset (i_rst_n=0, async): FIFO empty, FSM=IDLE, all outputs 0. This includes cyc/stb/we/adr/data, rsp_valid/data/err, err_count, level and busy. o_cmd_ready=0 while reset is asserted and 1 after release.
- Reset mid-transfer drops cyc/stb immediately and discards queued commands and any pending response.
- Push: at a rising edge with i_cmd_valid && o_cmd_ready, store {we, adr, data}; o_fifo_level increments.
- Push while full is not accepted; the FIFO is never overwritten.
- Push and pop in the same cycle leave the level unchanged.
- o_cmd_ready = (level != FIFO_DEPTH).
- FSM states: IDLE, BUS, RESP.
- IDLE: if FIFO non-empty, pop the head at the edge. Load o_wb_we/adr/data, assert o_wb_cyc=o_wb_stb=1, clear the timeout counter, go to BUS.
- BUS: cyc/stb/we/adr/data are held stable. The timeout counter increments each cycle.
  - i_wb_ack=1 sampled: drop cyc/stb at that edge. Capture o_rsp_data = we ? 0 : i_wb_data, set o_rsp_err=0 and o_rsp_valid=1, go to RESP.
  - Else, if the counter reaches TIMEOUT_CYCLES-1: drop cyc/stb, set o_rsp_data=0, o_rsp_err=1, o_rsp_valid=1, increment err_count (saturating), go to RESP.
  - If ack and timeout occur in the same cycle, ack wins.
- RESP: hold the response until i_rsp_ready; at that edge clear o_rsp_valid and go to IDLE.
  - RESP lasts at least one cycle, so cyc is low for at least one cycle between transfers. This flushes the slave's registered ack, which stays high one cycle after stb drops.
  - i_wb_ack outside BUS is ignored.
- Latency with an empty FIFO, idle FSM, and a slave with registered ack (ack one cycle after stb sampled):
  - command pushed at edge k
  - cyc/stb high after edge k+1
  - ack sampled at edge k+3, rsp_valid high after k+3
  - with i_rsp_ready held 1, the next command's stb rises after edge k+5
- The FIFO accepts new commands during BUS and RESP.
- Commands are issued strictly in push order, one outstanding transfer at a time.
- o_wb_we is 0 whenever cyc is 0.

Test Plan:
- Write then read, slave models registered ack: push write adr=0x0002 data=0x0064, then read adr=0x0002. Required: two responses in order, {data 0, err 0} then {data 0x0064, err 0}; cyc low at least 1 cycle between them; stb high exactly 2 cycles per transfer.
- Back-pressure: hold i_rsp_ready=0 and push 5 commands with FIFO_DEPTH=4. Required: first command on bus, 4 queued, o_cmd_ready=0, 6th push not accepted. Release ready: 5 responses in order, level returns to 0, o_busy falls.
- Timeout: slave never acks, TIMEOUT_CYCLES=16. Required: stb high exactly 16 cycles; response {data 0, err 1}; err_count=1. The following command to an acking slave completes normally.
- Ack on the final timeout cycle: ack arrives in the 16th stb cycle. Required: err=0, read data captured, err_count unchanged.
- Async reset mid-BUS with 2 commands queued. Required: cyc/stb fall without a clock edge; level=0, rsp_valid=0, err_count=0 after reset. No Wishbone cycle appears after release until a new push.
- Saturation: 260 consecutive timeouts. Required: o_err_count stops at 255.
